// File: rtl/cpu_pkg.sv
// Shared types for the sequencing stage: branch condition codes, sequencer
// states and the default program-counter width.
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT = 11;

  typedef enum logic [2:0] {
    ALWAYS = 3'd0,
    EQ     = 3'd1,
    NE     = 3'd2,
    LT     = 3'd3,
    GT     = 3'd4,
    CS     = 3'd5,
    CC     = 3'd6,
    RSVD   = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Evaluate a branch condition against the registered flags.
  function automatic logic cond_true(br_cond_e cond, logic z, logic n, logic c);
    logic r;
    r = 1'b0;
    case (cond)
      ALWAYS:  r = 1'b1;
      EQ:      r = z;
      NE:      r = ~z;
      LT:      r = n;
      GT:      r = ~z & ~n;
      CS:      r = c;
      CC:      r = ~c;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_target_lut.sv
// Absolute branch-target table: one synchronous write port, one combinational
// read port. A same-cycle write is not visible to the read until the next cycle.
module branch_target_lut #(
  parameter int unsigned LUT_N  = 16,
  parameter int unsigned LUT_AW = 4,
  parameter int unsigned DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LUT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LUT_N; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/flag_branch_unit.sv
// Sequencing stage after the ALU: registers z/n/c, resolves conditional
// branches against the registered flags and owns the program counter.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEFAULT,
  parameter int unsigned LUT_N  = 16,
  parameter int unsigned LUT_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              adv,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              flag_we,
  input  logic              br_en,
  input  logic [2:0]        br_cond,
  input  logic              br_abs,
  input  logic [7:0]        br_off,
  input  logic [LUT_AW-1:0] br_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  input  logic              halt,
  output logic [PC_W-1:0]   pc,
  output logic              z_q,
  output logic              n_q,
  output logic              c_q,
  output logic              taken,
  output logic              running,
  output logic              done
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_rdata;
  logic [PC_W-1:0]   rel_target;
  logic [PC_W-1:0]   target;

  branch_target_lut #(
    .LUT_N  (LUT_N),
    .LUT_AW (LUT_AW),
    .DATA_W (PC_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (br_idx),
    .rdata (lut_rdata)
  );

  assign running = (state_q == RUN);

  // Conditions use registered flags only; a coincident flag_we lands after the decision.
  assign taken = running & adv & br_en & ~halt &
                 cond_true(br_cond_e'(br_cond), z_q, n_q, c_q);

  assign rel_target = pc_q + {{(PC_W-8){br_off[7]}}, br_off};
  assign target     = br_abs ? lut_rdata : rel_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
        end
      end
      RUN: begin
        if (adv) begin
          if (halt) begin
            state_d = HALT;
            done_d  = 1'b1;
          end else if (taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else if (flag_we) begin
      z_q <= alu_z;
      n_q <= alu_n;
      c_q <= alu_c;
    end
  end

  assign pc   = pc_q;
  assign done = done_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Randomized bench for flag_branch_unit: a driver issues one stimulus per cycle
// and queues the expected response from a behavioural model; a monitor checks it.
module tb_flag_branch_unit;

  localparam int PC_W   = 11;
  localparam int LUT_N  = 16;
  localparam int LUT_AW = 4;
  localparam int PC_MOD = 2048;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [PC_W-1:0]   start_addr;
  logic              adv;
  logic              alu_z, alu_n, alu_c;
  logic              flag_we;
  logic              br_en;
  logic [2:0]        br_cond;
  logic              br_abs;
  logic [7:0]        br_off;
  logic [LUT_AW-1:0] br_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic              halt;
  logic [PC_W-1:0]   pc;
  logic              z_q, n_q, c_q;
  logic              taken, running, done;

  flag_branch_unit #(
    .PC_W   (PC_W),
    .LUT_N  (LUT_N),
    .LUT_AW (LUT_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .adv        (adv),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .flag_we    (flag_we),
    .br_en      (br_en),
    .br_cond    (br_cond),
    .br_abs     (br_abs),
    .br_off     (br_off),
    .br_idx     (br_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .halt       (halt),
    .pc         (pc),
    .z_q        (z_q),
    .n_q        (n_q),
    .c_q        (c_q),
    .taken      (taken),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit start;  int start_addr; bit adv;
    bit z; bit n; bit c; bit flag_we;
    bit br_en;  int cond; bit br_abs; int off; int idx;
    bit lut_we; int waddr; int wdata; bit halt;
  } stim_t;

  typedef struct {
    int pre_pc; bit pre_taken;
    int pc; bit z; bit n; bit c; bit running; bit done;
  } exp_t;

  exp_t sb[$];

  // Reference model: mode 0 idle, 1 running, 2 halted.
  int m_mode;
  int m_pc;
  bit mz, mn, mc;
  int m_lut [LUT_N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic step(input stim_t s, input bit do_rst);
    exp_t e;
    bit   run, cond, tk;
    int   off_s, tgt;
    @(negedge clk);
    start      = s.start;
    start_addr = PC_W'(s.start_addr);
    adv        = s.adv;
    alu_z      = s.z;
    alu_n      = s.n;
    alu_c      = s.c;
    flag_we    = s.flag_we;
    br_en      = s.br_en;
    br_cond    = 3'(s.cond);
    br_abs     = s.br_abs;
    br_off     = 8'(s.off);
    br_idx     = LUT_AW'(s.idx);
    lut_we     = s.lut_we;
    lut_waddr  = LUT_AW'(s.waddr);
    lut_wdata  = PC_W'(s.wdata);
    halt       = s.halt;
    if (do_rst) begin
      #1 rst_n = 1'b0;
      m_mode = 0; m_pc = 0; mz = 0; mn = 0; mc = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      e.pre_pc = 0; e.pre_taken = 0; e.done = 0;
    end else begin
      rst_n = 1'b1;
      run = (m_mode == 1);
      case (s.cond)
        0: cond = 1;
        1: cond = mz;
        2: cond = !mz;
        3: cond = mn;
        4: cond = !mz && !mn;
        5: cond = mc;
        6: cond = !mc;
        default: cond = 0;
      endcase
      tk = run && s.adv && s.br_en && !s.halt && cond;
      e.pre_pc = m_pc;
      e.pre_taken = tk;
      off_s = (s.off >= 128) ? s.off - 256 : s.off;
      tgt = s.br_abs ? m_lut[s.idx] : (m_pc + off_s + PC_MOD) % PC_MOD;
      e.done = run && s.adv && s.halt;
      if (m_mode == 1) begin
        if (s.adv) begin
          if (s.halt) m_mode = 2;
          else m_pc = tk ? tgt : (m_pc + 1) % PC_MOD;
        end
      end else if (s.start) begin
        m_mode = 1;
        m_pc = s.start_addr;
      end
      if (s.flag_we) begin mz = s.z; mn = s.n; mc = s.c; end
      if (s.lut_we) m_lut[s.waddr] = s.wdata;
    end
    e.pc = m_pc; e.z = mz; e.n = mn; e.c = mc;
    e.running = (m_mode == 1);
    sb.push_back(e);
  endtask

  // Monitor: pre-edge view (pc, taken) then post-edge registered state.
  initial begin
    exp_t e;
    logic [PC_W-1:0] obs_pc;
    logic obs_tk;
    forever begin
      @(negedge clk);
      #2;
      obs_pc = pc;
      obs_tk = taken;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pre_pc",  32'(obs_pc),  32'(e.pre_pc));
        chk("taken",   32'(obs_tk),  32'(e.pre_taken));
        chk("pc",      32'(pc),      32'(e.pc));
        chk("z_q",     32'(z_q),     32'(e.z));
        chk("n_q",     32'(n_q),     32'(e.n));
        chk("c_q",     32'(c_q),     32'(e.c));
        chk("running", 32'(running), 32'(e.running));
        chk("done",    32'(done),    32'(e.done));
        if (done && running) chk("done_excl_running", 32'(1), 32'(0));
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    start = 0; start_addr = '0; adv = 0; alu_z = 0; alu_n = 0; alu_c = 0;
    flag_we = 0; br_en = 0; br_cond = '0; br_abs = 0; br_off = '0; br_idx = '0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0; halt = 0;
    m_mode = 0; m_pc = 0; mz = 0; mn = 0; mc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;

    // Sequential run from 0x010
    step(nop(), 1);
    s = nop(); s.start = 1; s.start_addr = 'h010; step(s, 0);
    s = nop(); s.adv = 1; repeat (3) step(s, 0);

    // EQ / NE relative branches at 0x020
    step(nop(), 1);
    s = nop(); s.start = 1; s.start_addr = 'h020; step(s, 0);
    s = nop(); s.flag_we = 1; s.z = 1; step(s, 0);
    s = nop(); s.adv = 1; s.br_en = 1; s.cond = 1; s.off = 'hFC; step(s, 0);
    s.cond = 2; step(s, 0);

    // Flag write and branch in the same cycle
    s = nop(); s.flag_we = 1; step(s, 0);
    s = nop(); s.flag_we = 1; s.z = 1; s.adv = 1; s.br_en = 1; s.cond = 1; s.off = 'h40; step(s, 0);
    step(nop(), 0);

    // Absolute target, wrap at top of memory, negative relative wrap
    s = nop(); s.lut_we = 1; s.waddr = 3; s.wdata = 'h7F0; step(s, 0);
    s = nop(); s.adv = 1; s.br_en = 1; s.cond = 0; s.br_abs = 1; s.idx = 3;
    s.lut_we = 1; s.waddr = 3; s.wdata = 'h100; step(s, 0);
    s = nop(); s.lut_we = 1; s.waddr = 3; s.wdata = 'h7F0; step(s, 0);
    s = nop(); s.adv = 1; s.br_en = 1; s.cond = 0; s.br_abs = 1; s.idx = 3; step(s, 0);
    s = nop(); s.adv = 1; repeat (21) step(s, 0);
    s.br_en = 1; s.cond = 0; s.off = 'h80; step(s, 0);

    // Halt beats an ALWAYS branch; restart from HALT
    s = nop(); s.flag_we = 1; s.n = 1; s.c = 1; step(s, 0);
    s = nop(); s.adv = 1; s.halt = 1; s.br_en = 1; s.cond = 0; step(s, 0);
    s = nop(); s.adv = 1; repeat (2) step(s, 0);
    s = nop(); s.start = 1; s.start_addr = 'h055; step(s, 0);
    s = nop(); s.adv = 1; step(s, 0);

    // Start during RUN ignored, then asynchronous reset mid-run
    s = nop(); s.start = 1; s.start_addr = 'h200; step(s, 0);
    step(nop(), 1);
    s = nop(); s.start = 1; s.start_addr = 'h123; step(s, 0);
    s = nop(); s.flag_we = 1; s.c = 1; step(s, 0);
    step(nop(), 1);
    s = nop(); s.adv = 1; s.br_en = 1; s.br_abs = 1; s.idx = 3; step(s, 0);
    s = nop(); s.start = 1; s.start_addr = 'h7FE; step(s, 0);
    s = nop(); s.adv = 1; s.br_en = 1; s.br_abs = 1; s.idx = 3; step(s, 0);

    // Randomized traffic
    repeat (3000) begin
      s.start      = ($urandom_range(0, 19) == 0);
      s.start_addr = $urandom_range(0, PC_MOD - 1);
      s.adv        = ($urandom_range(0, 3) != 0);
      s.z          = $urandom_range(0, 1);
      s.n          = $urandom_range(0, 1);
      s.c          = $urandom_range(0, 1);
      s.flag_we    = ($urandom_range(0, 2) == 0);
      s.br_en      = ($urandom_range(0, 2) == 0);
      s.cond       = $urandom_range(0, 7);
      s.br_abs     = $urandom_range(0, 1);
      s.off        = $urandom_range(0, 255);
      s.idx        = $urandom_range(0, LUT_N - 1);
      s.lut_we     = ($urandom_range(0, 7) == 0);
      s.waddr      = $urandom_range(0, LUT_N - 1);
      s.wdata      = $urandom_range(0, PC_MOD - 1);
      s.halt       = ($urandom_range(0, 39) == 0);
      step(s, ($urandom_range(0, 299) == 0));
    end

    step(nop(), 0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sequencing stage directly downstream of the ALU.
- Registers the ALU condition flags (z, n, c), resolves conditional branches against them, and owns the 11-bit program counter that feeds fetch and the ALU's pc input.
- Registered carry is returned to the ALU as its carry-in.
- Provides the start/done program handshake to the test harness.

Parameters:
PC_W, 11, program counter width (instruction memory depth 2**PC_W).
LUT_N, 16, entries in the absolute branch-target table.
LUT_AW, 4, address width of the target table (log2 LUT_N).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  one-cycle pulse; begins program execution at start_addr
start_addr  input  PC_W  first instruction address
adv  input  1  current instruction retires this cycle (RUN only)
alu_z  input  1  ALU zero flag
alu_n  input  1  ALU negative flag
alu_c  input  1  ALU carry flag
flag_we  input  1  latch alu_z/alu_n/alu_c at this edge
br_en  input  1  current instruction is a branch
br_cond  input  3  0 ALWAYS, 1 EQ(z), 2 NE(!z), 3 LT(n), 4 GT(!z&!n), 5 CS(c), 6 CC(!c), 7 reserved (never taken)
br_abs  input  1  1: target = lut[br_idx]; 0: target = pc + sign-extended br_off
br_off  input  8  signed relative offset
br_idx  input  LUT_AW  target table index
lut_we  input  1  write target table (any state)
lut_waddr  input  LUT_AW  table write address
lut_wdata  input  PC_W  table write data
halt  input  1  current instruction is halt
pc  output  PC_W  current instruction address
z_q  output  1  registered zero flag
n_q  output  1  registered negative flag
c_q  output  1  registered carry, drives ALU carry-in
taken  output  1  combinational: branch taken this cycle
running  output  1  state == RUN
done  output  1  one-cycle pulse on entry to HALT

Behaviour:
- Reset values: pc=0, z_q=0, n_q=0, c_q=0, state IDLE, done=0, all LUT entries 0. Reset mid-RUN aborts immediately; no done pulse.
- FSM states: IDLE, RUN, HALT.
  - IDLE --start--> RUN; pc<=start_addr.
  - RUN --adv&halt--> HALT; pc holds; done=1 the following cycle only.
  - HALT --start--> RUN; pc<=start_addr; flags retained.
  - start in RUN is ignored.
- RUN, adv=1, halt=0:
  - If taken: pc<=target.
  - Otherwise pc<=pc+1.
- RUN, adv=0: pc holds; flag_we still honoured.
- taken = running & adv & br_en & cond_true(br_cond, z_q, n_q, c_q). taken is 0 outside RUN.
- Branch conditions read registered flags only. When flag_we and br_en coincide, the branch sees the old flags and the new flags land at the edge. No forwarding.
- halt and br_en together: halt wins; taken forced 0.
- Relative target is pc + sext(br_off), computed modulo 2**PC_W (wraps both ways). Absolute target is lut[br_idx].
- Sequential wrap: pc=2**PC_W-1 increments to 0.
- flag_we latches all three flags in any state.
- LUT write and read of the same index in the same cycle returns the old entry.
- done is registered; it is never asserted together with running.

Decomposition:
- Shared package (cpu_pkg) holds:
  - br_cond_e enum (ALWAYS..CC, RSVD);
  - state_e enum (IDLE, RUN, HALT);
  - PC_W default.
- One sub-module, branch_target_lut: LUT_N x PC_W register file with one synchronous write port and one combinational read port, asynchronous active-low reset to 0.
- FSM, flag register, condition evaluation and pc update stay in the top module.

Test Plan:
1. Reset then start=1, start_addr=0x010; 3 cycles adv=1 -> pc sequence 0x010, 0x011, 0x012, 0x013; running=1; done=0.
2. Flags z=1 written via flag_we; next cycle br_en=1, br_cond=EQ, br_abs=0, br_off=0xFC at pc=0x020 -> taken=1, pc=0x01C. Repeat with br_cond=NE -> taken=0, pc=0x021.
3. Same-cycle hazard: z_q=0, then flag_we with alu_z=1 and br_cond=EQ in the same cycle -> taken=0, pc+1, z_q=1 afterwards.
4. lut_we addr 3 data 0x7F0; absolute ALWAYS branch, br_idx=3 -> pc=0x7F0. Then pc=0x7FF with adv -> pc=0x000. Relative br_off=0x80 from pc=0x005 -> pc=0x785.
5. halt with br_en=1, ALWAYS -> taken=0, pc holds, done high exactly one cycle, running=0. start in HALT restarts at start_addr with flags unchanged.
6. rst_n low asynchronously mid-RUN (pc=0x123, c_q=1) -> pc=0, flags 0, IDLE, LUT cleared, no done pulse; start pulse during RUN ignored (pc unaffected).
